// File: rtl/softmax_norm_pkg.sv
// +----------------------------------------------------------------------------+
// | softmax_norm_pkg : shared types and helpers for the softmax normaliser     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package softmax_norm_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIVIDE  = 2'd1,
    OUTPUT  = 2'd2
  } softmax_state_t;

  localparam int unsigned FX_FRACTION = 24;
  localparam logic [31:0] ONE_FX      = 32'd1 << FX_FRACTION;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/softmax_norm_div.sv
// +----------------------------------------------------------------------------+
// | softmax_div : sequential restoring divider, FRACTION+1 quotient bits       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module softmax_div
  import softmax_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 36,
  parameter int unsigned FRACTION   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] numer,
  input  logic [ACC_WIDTH-1:0]  denom,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient
);

  localparam int unsigned REM_WIDTH = ACC_WIDTH + 1;
  localparam int unsigned CNT_WIDTH = clog2(FRACTION + 1);

  logic [REM_WIDTH-1:0] rem_q;
  logic [REM_WIDTH-1:0] den_q;
  logic [FRACTION:0]    quo_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 busy_q;
  logic                 done_q;

  logic [REM_WIDTH-1:0] w_rem;
  logic [REM_WIDTH-1:0] w_den;
  logic [REM_WIDTH-1:0] w_diff;
  logic                 w_ge;

  // The load cycle resolves the MSB directly from the operand ports, so the
  // remaining FRACTION bits finish exactly FRACTION+1 cycles after start.
  assign w_rem  = start ? REM_WIDTH'(numer) : rem_q;
  assign w_den  = start ? REM_WIDTH'(denom) : den_q;
  assign w_ge   = (w_rem >= w_den);
  assign w_diff = w_ge ? (w_rem - w_den) : w_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        den_q  <= w_den;
        rem_q  <= {w_diff[REM_WIDTH-2:0], 1'b0};
        quo_q  <= {{FRACTION{1'b0}}, w_ge};
        cnt_q  <= CNT_WIDTH'(FRACTION);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= {w_diff[REM_WIDTH-2:0], 1'b0};
        quo_q <= {quo_q[FRACTION-1:0], w_ge};
        cnt_q <= cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = DATA_WIDTH'(quo_q);

endmodule

`default_nettype wire

// File: rtl/softmax_norm.sv
// +----------------------------------------------------------------------------+
// | softmax_norm : buffers a vector of exp results and emits each / sum        |
// | Option macro: SOFTMAX_ZERO_SUM_GUARD_EN (zero-sum bypass + flag port)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module softmax_norm
  import softmax_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRACTION   = 24,
  parameter int unsigned VEC_LEN    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  sm_ready_in,
  input  logic                  sm_valid_in,
  input  logic [DATA_WIDTH-1:0] sm_data_in,
  input  logic                  sm_ready_out,
  output logic                  sm_valid_out,
  output logic [DATA_WIDTH-1:0] sm_data_out,
  output logic                  sm_last_out
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
  ,
  output logic                  sm_zero_sum_out
`endif
);

  localparam int unsigned ACC_WIDTH = DATA_WIDTH + clog2(VEC_LEN);
  localparam int unsigned IDX_WIDTH = clog2(VEC_LEN);
  localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(VEC_LEN - 1);

  softmax_state_t        state_q;
  logic [DATA_WIDTH-1:0] buf_q [VEC_LEN];
  logic [ACC_WIDTH-1:0]  sum_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  started_q;
  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  w_accept;
  logic                  w_skip;
  logic                  w_div_start;
  logic                  w_div_done;
  logic [DATA_WIDTH-1:0] w_quot;

`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
  logic zero_sum_q;
  assign w_skip          = (sum_q == '0);
  assign sm_zero_sum_out = zero_sum_q;
`else
  assign w_skip = 1'b0;
`endif

  assign sm_ready_in = (state_q == COLLECT);
  assign w_accept    = sm_valid_in & sm_ready_in;
  assign w_div_start = (state_q == DIVIDE) & ~started_q & ~w_skip;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      buf_q[idx_q] <= sm_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      sum_q      <= '0;
      idx_q      <= '0;
      started_q  <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
      zero_sum_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (w_accept) begin
            sum_q <= sum_q + ACC_WIDTH'(sm_data_in);
            if (idx_q == c_last_idx) begin
              idx_q   <= '0;
              state_q <= DIVIDE;
            end else begin
              idx_q <= idx_q + IDX_WIDTH'(1);
            end
          end
        end
        DIVIDE: begin
          if (w_skip) begin
            data_q     <= '0;
            valid_q    <= 1'b1;
            last_q     <= (idx_q == c_last_idx);
            state_q    <= OUTPUT;
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
            zero_sum_q <= 1'b1;
`endif
          end else if (w_div_done) begin
            data_q    <= w_quot;
            valid_q   <= 1'b1;
            last_q    <= (idx_q == c_last_idx);
            started_q <= 1'b0;
            state_q   <= OUTPUT;
          end else begin
            started_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (sm_ready_out) begin
            valid_q <= 1'b0;
            if (last_q) begin
              last_q     <= 1'b0;
              sum_q      <= '0;
              idx_q      <= '0;
              state_q    <= COLLECT;
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
              zero_sum_q <= 1'b0;
`endif
            end else begin
              idx_q   <= idx_q + IDX_WIDTH'(1);
              state_q <= DIVIDE;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  softmax_div #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .FRACTION  (FRACTION)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (w_div_start),
    .numer   (buf_q[idx_q]),
    .denom   (sum_q),
    .done    (w_div_done),
    .quotient(w_quot)
  );

  assign sm_valid_out = valid_q;
  assign sm_data_out  = data_q;
  assign sm_last_out  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_softmax_norm.sv
// +----------------------------------------------------------------------------+
// | tb_softmax_norm : randomised self-checking bench for softmax_norm          |
// | Honours SOFTMAX_ZERO_SUM_GUARD_EN when defined for the build. Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_softmax_norm;
  import softmax_norm_pkg::*;

  localparam int DW = 32;
  localparam int FR = 24;
  localparam int VL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sm_ready_in;
  logic          sm_valid_in = 1'b0;
  logic [DW-1:0] sm_data_in = '0;
  logic          sm_ready_out = 1'b1;
  logic          sm_valid_out;
  logic [DW-1:0] sm_data_out;
  logic          sm_last_out;
  logic          zs;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        zs;
    int          cyc;
  } rec_t;

  rec_t acc_q[$];
  rec_t out_q[$];

  softmax_norm #(
    .DATA_WIDTH(DW),
    .FRACTION  (FR),
    .VEC_LEN   (VL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sm_ready_in    (sm_ready_in),
    .sm_valid_in    (sm_valid_in),
    .sm_data_in     (sm_data_in),
    .sm_ready_out   (sm_ready_out),
    .sm_valid_out   (sm_valid_out),
    .sm_data_out    (sm_data_out),
    .sm_last_out    (sm_last_out)
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
    ,
    .sm_zero_sum_out(zs)
`endif
  );

`ifndef SOFTMAX_ZERO_SUM_GUARD_EN
  assign zs = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction log: every accepted input and every completed output.
  always @(negedge clk) begin
    if (!rst) begin
      if (sm_valid_in && sm_ready_in)   acc_q.push_back('{sm_data_in, 1'b0, 1'b0, cyc});
      if (sm_valid_out && sm_ready_out) out_q.push_back('{sm_data_out, sm_last_out, zs, cyc});
    end
  end

  // Softmax element i of vector v: floor(v[i] * 2^FR / sum(v)).
  function automatic logic [31:0] model(input logic [31:0] v[VL], input int i);
    longint unsigned s;
    s = 0;
    for (int j = 0; j < VL; j++) s += 64'(v[j]);
    if (s == 0) begin
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
      return 32'd0;
`else
      return (32'd1 << (FR + 1)) - 32'd1;
`endif
    end
    return 32'((64'(v[i]) << FR) / s);
  endfunction

  function automatic logic [31:0] rand_sample();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 1000));
    return $urandom;
  endfunction

  task automatic push(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    sm_valid_in = 1'b1;
    sm_data_in  = d;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sm_ready_in) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    sm_valid_in = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_timeout: got accepted=%0b want 1 (data %h)", ok, d);
    end
  endtask

  task automatic send_vec(input logic [31:0] v[VL]);
    for (int i = 0; i < VL; i++) push(v[i]);
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 2000 && out_q.size() < n; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sm_valid_in = 1'b0;
    sm_ready_out = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (sm_ready_in !== 1'b1) begin n_err++; $display("FAIL reset_ready_in: got %b want 1", sm_ready_in); end
    n_vec++; if (sm_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", sm_valid_out); end
    n_vec++; if (sm_data_out !== 32'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0", sm_data_out); end
    n_vec++; if (sm_last_out !== 1'b0) begin n_err++; $display("FAIL reset_last_out: got %b want 0", sm_last_out); end
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
    n_vec++; if (zs !== 1'b0) begin n_err++; $display("FAIL reset_zero_sum: got %b want 0", zs); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    acc_q.delete();
    out_q.delete();
  endtask

  task automatic test_uniform();
    logic [31:0] v[VL];
    int lat;
    for (int i = 0; i < VL; i++) v[i] = ONE_FX;
    acc_q.delete(); out_q.delete();
    sm_ready_out = 1'b1;
    send_vec(v);
    wait_out(VL);
    n_vec++;
    if (out_q.size() != VL) begin n_err++; $display("FAIL uniform_count: got %0d want %0d", out_q.size(), VL); end
    for (int i = 0; i < VL && i < out_q.size(); i++) begin
      n_vec++;
      if (out_q[i].data !== 32'h0040_0000 || out_q[i].last !== (i == VL - 1)) begin
        n_err++;
        $display("FAIL uniform_elem%0d: got data=%h last=%b want data=00400000 last=%b", i, out_q[i].data, out_q[i].last, i == VL - 1);
      end
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
      n_vec++; if (out_q[i].zs !== 1'b0) begin n_err++; $display("FAIL uniform_zs%0d: got %b want 0", i, out_q[i].zs); end
`endif
    end
    lat = (out_q.size() > 0 && acc_q.size() == VL) ? out_q[0].cyc - acc_q[VL-1].cyc : -1;
    n_vec++;
    if (lat != FR + 3) begin n_err++; $display("FAIL first_latency: got %0d want %0d", lat, FR + 3); end
    for (int i = 1; i < VL && i < out_q.size(); i++) begin
      n_vec++;
      if (out_q[i].cyc - out_q[i-1].cyc != FR + 3) begin
        n_err++;
        $display("FAIL elem_latency%0d: got %0d want %0d", i, out_q[i].cyc - out_q[i-1].cyc, FR + 3);
      end
    end
  endtask

  task automatic test_patterns();
    logic [31:0] v[VL];
    logic [31:0] fixed_exp[VL];
    v = '{32'h0100_0000, 32'h0300_0000, 32'h0, 32'h0};
    fixed_exp = '{32'h0040_0000, 32'h00C0_0000, 32'h0, 32'h0};
    for (int r = 0; r < 4; r++) begin
      if (r > 0) for (int i = 0; i < VL; i++) v[i] = rand_sample();
      acc_q.delete(); out_q.delete();
      sm_ready_out = 1'b1;
      send_vec(v);
      wait_out(VL);
      n_vec++;
      if (out_q.size() != VL) begin n_err++; $display("FAIL pattern%0d_count: got %0d want %0d", r, out_q.size(), VL); end
      for (int i = 0; i < VL && i < out_q.size(); i++) begin
        n_vec++;
        if (out_q[i].data !== model(v, i) || out_q[i].last !== (i == VL - 1)) begin
          n_err++;
          $display("FAIL pattern%0d_elem%0d: got data=%h last=%b want data=%h last=%b", r, i, out_q[i].data, out_q[i].last, model(v, i), i == VL - 1);
        end
        if (r == 0) begin
          n_vec++;
          if (out_q[i].data !== fixed_exp[i]) begin n_err++; $display("FAIL fixed_elem%0d: got %h want %h", i, out_q[i].data, fixed_exp[i]); end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] v[VL];
    logic [31:0] d;
    logic        l;
    for (int i = 0; i < VL; i++) v[i] = rand_sample() | 32'h1;
    acc_q.delete(); out_q.delete();
    sm_ready_out = 1'b0;
    send_vec(v);
    for (int k = 0; k < 200 && !sm_valid_out; k++) @(negedge clk);
    d = sm_data_out;
    l = sm_last_out;
    sm_valid_in = 1'b1;
    sm_data_in  = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (sm_valid_out !== 1'b1 || sm_data_out !== d || sm_last_out !== l || sm_ready_in !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got valid=%b data=%h last=%b rdy_in=%b want valid=1 data=%h last=%b rdy_in=0",
                 k, sm_valid_out, sm_data_out, sm_last_out, sm_ready_in, d, l);
      end
    end
    @(posedge clk); #1;
    sm_valid_in  = 1'b0;
    sm_ready_out = 1'b1;
    wait_out(VL);
    n_vec++;
    if (acc_q.size() != VL) begin n_err++; $display("FAIL stall_accepts: got %0d want %0d", acc_q.size(), VL); end
    n_vec++;
    if (out_q.size() != VL) begin n_err++; $display("FAIL stall_count: got %0d want %0d", out_q.size(), VL); end
    for (int i = 0; i < VL && i < out_q.size(); i++) begin
      n_vec++;
      if (out_q[i].data !== model(v, i) || out_q[i].last !== (i == VL - 1)) begin
        n_err++;
        $display("FAIL stall_elem%0d: got data=%h last=%b want data=%h last=%b", i, out_q[i].data, out_q[i].last, model(v, i), i == VL - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v[VL];
    sm_ready_out = 1'b1;
    push(rand_sample());
    push(rand_sample());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_q.delete(); out_q.delete();
    @(negedge clk);
    n_vec++;
    if (sm_ready_in !== 1'b1) begin n_err++; $display("FAIL midreset_ready_in: got %b want 1", sm_ready_in); end
    @(posedge clk); #1;
    for (int i = 0; i < VL; i++) v[i] = 32'h0200_0000;
    send_vec(v);
    wait_out(VL);
    n_vec++;
    if (out_q.size() != VL) begin n_err++; $display("FAIL midreset_count: got %0d want %0d", out_q.size(), VL); end
    for (int i = 0; i < VL && i < out_q.size(); i++) begin
      n_vec++;
      if (out_q[i].data !== 32'h0040_0000 || out_q[i].last !== (i == VL - 1)) begin
        n_err++;
        $display("FAIL midreset_elem%0d: got data=%h last=%b want data=00400000 last=%b", i, out_q[i].data, out_q[i].last, i == VL - 1);
      end
    end
  endtask

  task automatic test_zero_sum();
    logic [31:0] v[VL];
    for (int i = 0; i < VL; i++) v[i] = 32'h0;
    acc_q.delete(); out_q.delete();
    sm_ready_out = 1'b1;
    send_vec(v);
    wait_out(VL);
    n_vec++;
    if (out_q.size() != VL) begin n_err++; $display("FAIL zero_count: got %0d want %0d", out_q.size(), VL); end
    for (int i = 0; i < VL && i < out_q.size(); i++) begin
      n_vec++;
      if (out_q[i].data !== model(v, i) || out_q[i].last !== (i == VL - 1)) begin
        n_err++;
        $display("FAIL zero_elem%0d: got data=%h last=%b want data=%h last=%b", i, out_q[i].data, out_q[i].last, model(v, i), i == VL - 1);
      end
`ifdef SOFTMAX_ZERO_SUM_GUARD_EN
      n_vec++;
      if (out_q[i].zs !== 1'b1) begin n_err++; $display("FAIL zero_flag%0d: got %b want 1", i, out_q[i].zs); end
      if (i > 0) begin
        n_vec++;
        if (out_q[i].cyc - out_q[i-1].cyc != 2) begin
          n_err++;
          $display("FAIL zero_spacing%0d: got %0d want 2", i, out_q[i].cyc - out_q[i-1].cyc);
        end
      end
`else
      n_vec++;
      if (out_q[i].data !== 32'h01FF_FFFF) begin n_err++; $display("FAIL zero_allones%0d: got %h want 01ffffff", i, out_q[i].data); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v0[VL];
    logic [31:0] v1[VL];
    int gap;
    for (int i = 0; i < VL; i++) begin
      v0[i] = $urandom | 32'h8000_0000;
      v1[i] = 32'($urandom_range(1, 4000)) << 12;
    end
    acc_q.delete(); out_q.delete();
    sm_ready_out = 1'b1;
    fork
      begin
        send_vec(v0);
        send_vec(v1);
      end
      wait_out(2 * VL);
    join
    wait_out(2 * VL);
    n_vec++;
    if (out_q.size() != 2 * VL) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", out_q.size(), 2 * VL); end
    gap = (acc_q.size() == 2 * VL && out_q.size() >= VL) ? acc_q[VL].cyc - out_q[VL-1].cyc : -1;
    n_vec++;
    if (gap < 1) begin n_err++; $display("FAIL b2b_accept_order: got gap %0d want >=1", gap); end
    for (int i = 0; i < 2 * VL && i < out_q.size(); i++) begin
      logic [31:0] e;
      e = (i < VL) ? model(v0, i) : model(v1, i - VL);
      n_vec++;
      if (out_q[i].data !== e || out_q[i].last !== ((i % VL) == VL - 1)) begin
        n_err++;
        $display("FAIL b2b_elem%0d: got data=%h last=%b want data=%h last=%b", i, out_q[i].data, out_q[i].last, e, (i % VL) == VL - 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_uniform();
    test_patterns();
    test_stall();
    test_reset_mid();
    test_zero_sum();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
